// File: rtl/sram_16b_bridge.sv
// sram_16b_bridge: runs one 32-bit LSU word request as two 16-bit accesses on an
// IS61WV25616 asynchronous SRAM, with a programmable wait count per half access.
// Optional feature macro: SRAM_BRIDGE_RANGE_CHECK_EN (address window check on
// ADDR_MIN..ADDR_MAX; out-of-range requests complete with o_ERR and no SRAM access).
module sram_16b_bridge #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] ADDR_MIN    = 32'h2000,
    parameter logic [31:0] ADDR_MAX    = 32'h3FFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_ADDR,
    input  logic [31:0] i_WDATA,
    input  logic [3:0]  i_BMASK,
    input  logic        i_WREN,
    input  logic        i_RDEN,
    output logic [31:0] o_RDATA,
    output logic        o_ACK,
    output logic        o_ERR,
    output logic [17:0] o_SRAM_ADDR,
    output logic [15:0] o_SRAM_DQ,
    output logic        o_SRAM_DQ_OE,
    input  logic [15:0] i_SRAM_DQ,
    output logic        o_SRAM_CE_N,
    output logic        o_SRAM_OE_N,
    output logic        o_SRAM_WE_N,
    output logic        o_SRAM_LB_N,
    output logic        o_SRAM_UB_N
);

    localparam int unsigned PHASE_LEN = WAIT_CYCLES + 2;
    localparam int unsigned CNT_W     = $clog2(PHASE_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_LEN - 1);
    localparam logic [CNT_W-1:0] WE_FIRST = CNT_W'(1);
    localparam logic [CNT_W-1:0] WE_LAST  = CNT_W'(PHASE_LEN - 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [16:0]      r_word;
    logic [31:0]      r_wdata;
    logic [3:0]       r_mask;
    logic             r_write;
    logic             r_ack;
    logic [31:0]      r_rdata;
    logic [17:0]      r_sram_addr;
    logic [15:0]      r_sram_dq;
    logic             r_dq_oe;
    logic             r_ce_n;
    logic             r_oe_n;
    logic             r_we_n;
    logic             r_lb_n;
    logic             r_ub_n;

    logic [1:0]       w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_accept;
    logic             w_range_bad;
    logic             w_op_write;
    logic [16:0]      w_op_word;
    logic [31:0]      w_op_data;
    logic [3:0]       w_op_mask;
    logic             w_hi;
    logic [17:0]      w_addr_nx;
    logic [15:0]      w_dq_nx;
    logic             w_dq_oe_nx;
    logic             w_ce_n_nx;
    logic             w_oe_n_nx;
    logic             w_we_n_nx;
    logic             w_lb_n_nx;
    logic             w_ub_n_nx;
    logic             w_lo_end;
    logic             w_hi_end;

`ifdef SRAM_BRIDGE_RANGE_CHECK_EN
    logic r_bad;
    logic r_err;

    // Address window check on the full byte address of the incoming request.
    assign w_range_bad = (i_ADDR < ADDR_MIN) || (i_ADDR > ADDR_MAX);
    assign o_ERR       = r_err;

    // Remember whether the accepted request was out of range; pulse error with ack.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_bad <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_bad <= w_range_bad;
            end
            r_err <= (r_state == S_DONE) && r_bad;
        end
    end
`else
    logic w_unused_cfg;

    // Upper address bits alias and the window bounds have no function here.
    assign w_range_bad  = 1'b0;
    assign o_ERR        = 1'b0;
    assign w_unused_cfg = ^{ADDR_MIN, ADDR_MAX, i_ADDR[31:19], i_ADDR[1:0]};
`endif

    assign w_lo_end = (r_state == S_LO) && (r_cnt == CNT_LAST);
    assign w_hi_end = (r_state == S_HI) && (r_cnt == CNT_LAST);

    // Next state, phase counter and next values of the registered SRAM pins.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_accept   = 1'b0;
        w_hi       = 1'b0;
        w_addr_nx  = r_sram_addr;
        w_dq_nx    = r_sram_dq;
        w_dq_oe_nx = 1'b0;
        w_ce_n_nx  = 1'b1;
        w_oe_n_nx  = 1'b1;
        w_we_n_nx  = 1'b1;
        w_lb_n_nx  = 1'b1;
        w_ub_n_nx  = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (i_WREN || i_RDEN) begin
                    w_accept = 1'b1;
                    w_cnt_nx = '0;
                    if (w_range_bad) begin
                        w_state_nx = S_DONE;
                    end else if (!i_WREN) begin
                        w_state_nx = S_LO;
                    end else if (|i_BMASK[1:0]) begin
                        w_state_nx = S_LO;
                    end else if (|i_BMASK[3:2]) begin
                        w_state_nx = S_HI;
                    end else begin
                        w_state_nx = S_DONE;
                    end
                end
            end
            S_LO: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx   = '0;
                    w_state_nx = (!r_write || (|r_mask[3:2])) ? S_HI : S_DONE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_HI: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_DONE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        w_op_write = w_accept ? i_WREN         : r_write;
        w_op_word  = w_accept ? i_ADDR[18:2]   : r_word;
        w_op_data  = w_accept ? i_WDATA        : r_wdata;
        w_op_mask  = w_accept ? i_BMASK        : r_mask;

        if ((w_state_nx == S_LO) || (w_state_nx == S_HI)) begin
            w_hi      = (w_state_nx == S_HI);
            w_ce_n_nx = 1'b0;
            w_addr_nx = {w_op_word, w_hi};
            if (w_op_write) begin
                w_dq_oe_nx = 1'b1;
                w_dq_nx    = w_hi ? w_op_data[31:16] : w_op_data[15:0];
                w_we_n_nx  = !((w_cnt_nx >= WE_FIRST) && (w_cnt_nx <= WE_LAST));
                w_lb_n_nx  = ~(w_hi ? w_op_mask[2] : w_op_mask[0]);
                w_ub_n_nx  = ~(w_hi ? w_op_mask[3] : w_op_mask[1]);
            end else begin
                w_oe_n_nx = 1'b0;
                w_lb_n_nx = 1'b0;
                w_ub_n_nx = 1'b0;
            end
        end
    end

    // State register plus registered SRAM controls and completion pulse.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ack       <= 1'b0;
            r_sram_addr <= '0;
            r_sram_dq   <= '0;
            r_dq_oe     <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_ub_n      <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_ack       <= (r_state == S_DONE);
            r_sram_addr <= w_addr_nx;
            r_sram_dq   <= w_dq_nx;
            r_dq_oe     <= w_dq_oe_nx;
            r_ce_n      <= w_ce_n_nx;
            r_oe_n      <= w_oe_n_nx;
            r_we_n      <= w_we_n_nx;
            r_lb_n      <= w_lb_n_nx;
            r_ub_n      <= w_ub_n_nx;
        end
    end

    // Request latch and read-data capture at the end of each read half.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_word  <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
            r_write <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_word  <= i_ADDR[18:2];
                r_wdata <= i_WDATA;
                r_mask  <= i_BMASK;
                r_write <= i_WREN;
                if (w_range_bad && !i_WREN) begin
                    r_rdata <= '0;
                end
            end
            if (!r_write && w_lo_end) begin
                r_rdata[15:0] <= i_SRAM_DQ;
            end
            if (!r_write && w_hi_end) begin
                r_rdata[31:16] <= i_SRAM_DQ;
            end
        end
    end

    assign o_RDATA      = r_rdata;
    assign o_ACK        = r_ack;
    assign o_SRAM_ADDR  = r_sram_addr;
    assign o_SRAM_DQ    = r_sram_dq;
    assign o_SRAM_DQ_OE = r_dq_oe;
    assign o_SRAM_CE_N  = r_ce_n;
    assign o_SRAM_OE_N  = r_oe_n;
    assign o_SRAM_WE_N  = r_we_n;
    assign o_SRAM_LB_N  = r_lb_n;
    assign o_SRAM_UB_N  = r_ub_n;

endmodule

// File: tb/tb_sram_16b_bridge.sv
// Bench for sram_16b_bridge: directed cases plus random requests, checked cycle by
// cycle against a phase/timing model and a byte-level reference memory.
module tb_sram_16b_bridge;

    localparam int unsigned WAIT_CYCLES = 1;
    localparam int unsigned N           = WAIT_CYCLES + 2;
    localparam logic [31:0] ADDR_MIN    = 32'h2000;
    localparam logic [31:0] ADDR_MAX    = 32'h3FFF;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic        wren;
    logic        rden;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic        lb_n;
    logic        ub_n;

    logic [15:0] sram_mem [0:262143];
    logic [15:0] ref_mem  [0:262143];
    logic [31:0] exp_rdata;

    int n_checks;
    int n_fail;

    sram_16b_bridge #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .ADDR_MIN    (ADDR_MIN),
        .ADDR_MAX    (ADDR_MAX)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ADDR       (addr),
        .i_WDATA      (wdata),
        .i_BMASK      (bmask),
        .i_WREN       (wren),
        .i_RDEN       (rden),
        .o_RDATA      (rdata),
        .o_ACK        (ack),
        .o_ERR        (err),
        .o_SRAM_ADDR  (sram_addr),
        .o_SRAM_DQ    (sram_dq_out),
        .o_SRAM_DQ_OE (sram_dq_oe),
        .i_SRAM_DQ    (sram_dq_in),
        .o_SRAM_CE_N  (ce_n),
        .o_SRAM_OE_N  (oe_n),
        .o_SRAM_WE_N  (we_n),
        .o_SRAM_LB_N  (lb_n),
        .o_SRAM_UB_N  (ub_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM: reads drive the bus while selected, writes land mid-cycle.
    assign sram_dq_in = (!ce_n && !oe_n) ? sram_mem[sram_addr] : 16'h5A5A;

    always @(negedge clk) begin
        if (!ce_n && !we_n && sram_dq_oe) begin
            if (!lb_n) sram_mem[sram_addr][7:0]  <= sram_dq_out[7:0];
            if (!ub_n) sram_mem[sram_addr][15:8] <= sram_dq_out[15:8];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic range_bad(input logic [31:0] a);
`ifdef SRAM_BRIDGE_RANGE_CHECK_EN
        return (a < ADDR_MIN) || (a > ADDR_MAX);
`else
        return 1'b0;
`endif
    endfunction

    // Drive one request (called just after a negedge) and check every cycle until ack.
    task automatic do_req(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m);
        logic        is_wr;
        logic        bad;
        int          nph;
        int          ph [2];
        logic [16:0] word;
        logic [15:0] half;
        logic [7:0]  ctl_exp;
        int          p;
        int          c;
        is_wr = wr;
        bad   = range_bad(a);
        word  = a[18:2];
        nph   = 0;
        ph[0] = 0;
        ph[1] = 1;
        if (!bad) begin
            if (is_wr) begin
                if (m[1:0] != 2'b00) begin ph[nph] = 0; nph++; end
                if (m[3:2] != 2'b00) begin ph[nph] = 1; nph++; end
            end else begin
                nph = 2;
            end
        end
        addr = a; wdata = d; bmask = m; wren = wr; rden = rd;
        @(posedge clk);
        #1;
        wren = 1'b0; rden = 1'b0;
        addr = $urandom; wdata = $urandom; bmask = 4'($urandom);
        if (is_wr && !bad) begin
            half = ref_mem[{word, 1'b0}];
            if (m[0]) half[7:0]  = d[7:0];
            if (m[1]) half[15:8] = d[15:8];
            ref_mem[{word, 1'b0}] = half;
            half = ref_mem[{word, 1'b1}];
            if (m[2]) half[7:0]  = d[23:16];
            if (m[3]) half[15:8] = d[31:24];
            ref_mem[{word, 1'b1}] = half;
        end else if (!is_wr) begin
            exp_rdata = bad ? 32'h0 : {ref_mem[{word, 1'b1}], ref_mem[{word, 1'b0}]};
        end
        for (int j = 0; j <= nph * int'(N) + 1; j++) begin
            @(negedge clk);
            if (j < nph * int'(N)) begin
                p = ph[j / int'(N)];
                c = j % int'(N);
                if (is_wr)
                    ctl_exp = {1'b0, 1'b0, 1'b0, 1'b1,
                               !((c >= 1) && (c <= int'(N) - 2)),
                               ~m[2*p], ~m[2*p+1], 1'b1};
                else
                    ctl_exp = 8'b0000_1000;
                check_eq("sram_addr", 64'(sram_addr), 64'({word, p[0]}));
                if (is_wr)
                    check_eq("sram_dq", 64'(sram_dq_out), (p == 1) ? 64'(d[31:16]) : 64'(d[15:0]));
            end else if (j == nph * int'(N)) begin
                ctl_exp = 8'b0011_1110;
            end else begin
                ctl_exp = {1'b1, bad, 6'b11_1110};
            end
            check_eq("ctl{ack,err,ce,oe,we,lb,ub,dqoe}",
                     64'({ack, err, ce_n, oe_n, we_n, lb_n, ub_n, sram_dq_oe}), 64'(ctl_exp));
        end
        check_eq("rdata_at_ack", 64'(rdata), 64'(exp_rdata));
    endtask

    initial begin
        logic [31:0] ra;
        int          op;
        n_checks  = 0;
        n_fail    = 0;
        exp_rdata = 32'h0;
        rst = 1'b0;
        addr = '0; wdata = '0; bmask = '0; wren = 1'b0; rden = 1'b0;
        for (int i = 0; i < 262144; i++) begin
            sram_mem[i] = 16'h0;
            ref_mem[i]  = 16'h0;
        end
        repeat (3) @(negedge clk);
        check_eq("reset_ctl", 64'({ack, err, ce_n, oe_n, we_n, lb_n, ub_n, sram_dq_oe}), 64'(8'b0011_1110));
        check_eq("reset_addr", 64'(sram_addr), 64'h0);
        check_eq("reset_dq", 64'(sram_dq_out), 64'h0);
        check_eq("reset_rdata", 64'(rdata), 64'h0);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases
        do_req(1'b1, 1'b0, 32'h2004, 32'hDEADBEEF, 4'b1111);
        do_req(1'b0, 1'b1, 32'h2004, 32'h0, 4'b0000);
        check_eq("readback_value", 64'(rdata), 64'hDEADBEEF);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("rdata_hold", 64'({ack, rdata}), 64'({1'b0, 32'hDEADBEEF}));
        end
        do_req(1'b1, 1'b0, 32'h2008, 32'h12345678, 4'b1100);
        do_req(1'b1, 1'b0, 32'h200C, 32'hCAFEF00D, 4'b0000);
        do_req(1'b1, 1'b1, 32'h2010, 32'hA1B2C3D4, 4'b1111);
        do_req(1'b0, 1'b1, 32'h2010, 32'h0, 4'b0000);
        do_req(1'b0, 1'b1, 32'h2008, 32'h0, 4'b0000);
        do_req(1'b0, 1'b1, 32'h4000, 32'h0, 4'b0000);

        // Random traffic with back-to-back and gapped requests
        for (int t = 0; t < 80; t++) begin
            op = int'($urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0)
                ra = $urandom;
            else
                ra = 32'h2000 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
            do_req(op != 0, op != 1, ra, $urandom, 4'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a write's strobe cycle
        do_req(1'b0, 1'b1, 32'h2004, 32'h0, 4'b0000);
        addr = 32'h2014; wdata = 32'h55AA33CC; bmask = 4'b1111; wren = 1'b1; rden = 1'b0;
        @(posedge clk);
        #1;
        wren = 1'b0;
        @(posedge clk);
        #1;
        check_eq("pre_abort_strobe", 64'({ce_n, we_n}), 64'(2'b00));
        #1;
        rst = 1'b0;
        #1;
        check_eq("abort_ctl", 64'({ack, err, ce_n, oe_n, we_n, lb_n, ub_n, sram_dq_oe}), 64'(8'b0011_1110));
        check_eq("abort_addr_dq", 64'({sram_addr, sram_dq_out}), 64'h0);
        check_eq("abort_rdata", 64'(rdata), 64'h0);
        exp_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3 * int'(N) + 4; k++) begin
            @(negedge clk);
            check_eq("no_ack_after_abort", 64'({ack, ce_n}), 64'(2'b01));
        end
        do_req(1'b0, 1'b1, 32'h2014, 32'h0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
